// File: rtl/prbs_generator.sv
// prbs_generator: byte-parallel PRBS31 (x^31+x^28+1) source with single and periodic bit-error injection.
module prbs_generator #(
  parameter logic [30:0] SEED  = 31'h597957A0,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             inj_single,
  input  logic [2:0]       inj_bit,
  input  logic [15:0]      inj_period,
  output logic [7:0]       prbs,
  output logic             valid,
  output logic             busy,
  output logic [15:0]      err_inj_cnt,
  output logic [CNT_W-1:0] byte_cnt
);
  localparam logic [30:0] SEED_EFF = (SEED == 31'd0) ? 31'd1 : SEED;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [30:0]      d_q, d_d;
  logic [7:0]       prbs_q, prbs_d, n, mask;
  logic             valid_q, valid_d, pend_q, pend_d, phit, hit;
  logic [15:0]      pcnt_q, pcnt_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      d_q     <= SEED_EFF;
      prbs_q  <= 8'h00;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      pcnt_q  <= 16'd0;
      err_q   <= 16'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      prbs_q  <= prbs_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    // eight serial steps of the LFSR collapse to one XOR of two 8-bit windows
    n       = d_q[30:23] ^ d_q[27:20];
    phit    = (inj_period != 16'd0) && (pcnt_q >= inj_period - 16'd1);
    hit     = pend_q | phit;
    mask    = hit ? (8'h01 << inj_bit) : 8'h00;
    state_d = state_q;
    d_d     = d_q;
    prbs_d  = prbs_q;
    valid_d = 1'b0;
    pend_d  = pend_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start && !stop) begin
        state_d = RUN;
        pend_d  = 1'b0;
        pcnt_d  = 16'd0;
        err_d   = 16'd0;
        cnt_d   = '0;
      end
    end else if (stop) begin
      state_d = IDLE;
      d_d     = SEED_EFF;
      prbs_d  = 8'h00;
    end else begin
      pend_d = en ? (!pend_q && inj_single) : (pend_q || inj_single);
      if (en) begin
        d_d     = {d_q[22:0], n};
        prbs_d  = n ^ mask;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        pcnt_d  = phit ? 16'd0 : pcnt_q + 16'd1;
        err_d   = (hit && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
      end
    end
  end
  assign prbs        = prbs_q;
  assign valid       = valid_q;
  assign busy        = (state_q == RUN);
  assign err_inj_cnt = err_q;
  assign byte_cnt    = cnt_q;
endmodule

// File: tb/tb_prbs_generator.sv
// tb_prbs_generator: directed checks of prbs_generator against a bit-serial PRBS31 reference.
module tb_prbs_generator;
  logic        clk = 1'b0;
  logic        reset_n, start, stop, en, inj_single;
  logic [2:0]  inj_bit;
  logic [15:0] inj_period;
  logic [7:0]  prbs;
  logic        valid, busy;
  logic [15:0] err_inj_cnt;
  logic [31:0] byte_cnt;
  int          errors = 0, checks = 0;
  logic [30:0] md;

  prbs_generator dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .en(en),
    .inj_single(inj_single), .inj_bit(inj_bit), .inj_period(inj_period),
    .prbs(prbs), .valid(valid), .busy(busy), .err_inj_cnt(err_inj_cnt), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // serial reference: one wire bit per step, oldest bit lands in b[7]
  task automatic model_next(output logic [7:0] b);
    logic nb;
    for (int i = 7; i >= 0; i--) begin
      nb   = md[30] ^ md[27];
      b[i] = nb;
      md   = {md[29:0], nb};
    end
  endtask

  task automatic restart();
    en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    md = 31'h597957A0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; inj_single = 1'b0;
    inj_bit = 3'd0; inj_period = 16'd0;
    #2;
    if ({prbs, valid, busy} !== 10'd0) begin errors++; $display("FAIL reset_out got prbs=%h valid=%b busy=%b want 0", prbs, valid, busy); end
    checks++;
    if (err_inj_cnt !== 16'd0 || byte_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got err=%0d bytes=%0d want 0", err_inj_cnt, byte_cnt); end
    checks++;
    #10 reset_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    md = 31'h597957A0;
    if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL start_busy got busy=%b valid=%b want 1 0", busy, valid); end
    checks++;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      model_next(e);
      if (i == 0 && prbs !== 8'h25) begin errors++; $display("FAIL first_byte got %h want 25", prbs); end
      if (i == 0) checks++;
      if (valid !== 1'b1 || prbs !== e) begin errors++; $display("FAIL seq_byte%0d got %h/%b want %h/1", i, prbs, valid, e); end
      checks++;
    end
    en = 1'b0;
    if (byte_cnt !== 32'd4) begin errors++; $display("FAIL byte_cnt4 got %0d want 4", byte_cnt); end
    checks++;
  endtask

  task automatic test_periodic();
    logic [7:0] e;
    restart();
    inj_period = 16'd4; inj_bit = 3'd5; en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      model_next(e);
      if (i % 4 == 0) e ^= 8'h20;
      if (prbs !== e) begin errors++; $display("FAIL periodic_byte%0d got %h want %h", i, prbs, e); end
      checks++;
    end
    en = 1'b0;
    if (err_inj_cnt !== 16'd25) begin errors++; $display("FAIL periodic_err got %0d want 25", err_inj_cnt); end
    checks++;
    if (byte_cnt !== 32'd100) begin errors++; $display("FAIL periodic_bytes got %0d want 100", byte_cnt); end
    checks++;
    inj_period = 16'd1; inj_bit = 3'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      model_next(e);
      if (prbs !== (e ^ 8'h01)) begin errors++; $display("FAIL period1_byte%0d got %h want %h", i, prbs, e ^ 8'h01); end
      checks++;
    end
    en = 1'b0; inj_period = 16'd0;
    if (err_inj_cnt !== 16'd28) begin errors++; $display("FAIL period1_err got %0d want 28", err_inj_cnt); end
    checks++;
  endtask

  task automatic test_single();
    logic [7:0] e;
    restart();
    inj_bit = 3'd3; inj_single = 1'b1; tick();
    inj_single = 1'b0; tick();
    inj_single = 1'b1; tick(); inj_single = 1'b0;
    if (valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b want 0", valid); end
    checks++;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      model_next(e);
      if (i == 0) e ^= 8'h08;
      if (prbs !== e) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, prbs, e); end
      checks++;
    end
    en = 1'b0;
    if (err_inj_cnt !== 16'd1) begin errors++; $display("FAIL single_err got %0d want 1", err_inj_cnt); end
    checks++;
  endtask

  task automatic test_en_hold();
    logic [7:0] e, last;
    restart();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); model_next(e); end
    last = e;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid !== 1'b0 || prbs !== last) begin errors++; $display("FAIL hold%0d got %h/%b want %h/0", i, prbs, valid, last); end
      checks++;
    end
    en = 1'b1; tick(); model_next(e); en = 1'b0;
    if (valid !== 1'b1 || prbs !== e) begin errors++; $display("FAIL resume got %h/%b want %h/1", prbs, valid, e); end
    checks++;
    if (byte_cnt !== 32'd3) begin errors++; $display("FAIL hold_bytes got %0d want 3", byte_cnt); end
    checks++;
  endtask

  task automatic test_async_reset();
    restart();
    en = 1'b1; tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    if ({prbs, valid, busy} !== 10'd0) begin errors++; $display("FAIL async_rst got prbs=%h valid=%b busy=%b want 0", prbs, valid, busy); end
    checks++;
    #10 reset_n = 1'b1;
    tick(); tick();
    if (valid !== 1'b0 || busy !== 1'b0 || prbs !== 8'h00) begin errors++; $display("FAIL post_rst_idle got %h/%b/%b want 00/0/0", prbs, valid, busy); end
    checks++;
    en = 1'b0; start = 1'b1; tick(); start = 1'b0; en = 1'b1; tick(); en = 1'b0;
    if (prbs !== 8'h25 || valid !== 1'b1) begin errors++; $display("FAIL rst_restart got %h/%b want 25/1", prbs, valid); end
    checks++;
  endtask

  task automatic test_start_stop();
    en = 1'b1; stop = 1'b1; tick(); stop = 1'b0; en = 1'b0;
    if (busy !== 1'b0 || valid !== 1'b0 || prbs !== 8'h00) begin errors++; $display("FAIL stop_run got %h/%b/%b want 00/0/0", prbs, valid, busy); end
    checks++;
    if (byte_cnt !== 32'd1) begin errors++; $display("FAIL stop_hold_cnt got %0d want 1", byte_cnt); end
    checks++;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle got busy=%b want 0", busy); end
    checks++;
    start = 1'b1; tick(); start = 1'b0; en = 1'b1; tick(); en = 1'b0;
    if (prbs !== 8'h25 || busy !== 1'b1) begin errors++; $display("FAIL stop_restart got %h busy=%b want 25 1", prbs, busy); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_single();
    test_en_hold();
    test_async_reset();
    test_start_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
